audio_clk_gen: RTL

AUDIO_CLK_GEN -- requirements
Module: audio_clk_gen

---
 rtl/audio_clk_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/audio_clk_gen.sv
// Audio clock generator: lrclk/bclk/sample_tick from a 12.288 MHz master.
// Rate changes and stop requests take effect only on frame boundaries.
module audio_clk_gen #(
    parameter int DIV0           = 256,
    parameter int DIV1           = 384,
    parameter int DIV2           = 768,
    parameter int DIV3           = 1536,
    parameter int BCLK_PER_FRAME = 64,
    parameter int CNT_W          = 11
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  rate_sel,
    output logic        lrclk,
    output logic        bclk,
    output logic        sample_tick,
    output logic [1:0]  active_rate,
    output logic        rate_pending,
    output logic        running,
    output logic [15:0] frame_cnt_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int BP = 2 * BCLK_PER_FRAME;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [1:0]       rate_q, rate_d;
    logic             lrclk_q, lrclk_d;
    logic             bclk_q, bclk_d;
    logic             tick_q, tick_d;
    logic [15:0]      frame_q;
    logic [CNT_W-1:0] last_c, half_c, hlast_c;
    logic             run_w, wrap, start;

    // Frame geometry of the rate currently applied.
    always_comb begin
        last_c  = CNT_W'(DIV0 - 1);
        half_c  = CNT_W'(DIV0 / 2);
        hlast_c = CNT_W'(DIV0 / BP - 1);
        unique case (rate_q)
            2'd0: begin
                last_c  = CNT_W'(DIV0 - 1);
                half_c  = CNT_W'(DIV0 / 2);
                hlast_c = CNT_W'(DIV0 / BP - 1);
            end
            2'd1: begin
                last_c  = CNT_W'(DIV1 - 1);
                half_c  = CNT_W'(DIV1 / 2);
                hlast_c = CNT_W'(DIV1 / BP - 1);
            end
            2'd2: begin
                last_c  = CNT_W'(DIV2 - 1);
                half_c  = CNT_W'(DIV2 / 2);
                hlast_c = CNT_W'(DIV2 / BP - 1);
            end
            2'd3: begin
                last_c  = CNT_W'(DIV3 - 1);
                half_c  = CNT_W'(DIV3 / 2);
                hlast_c = CNT_W'(DIV3 / BP - 1);
            end
        endcase
    end

    assign run_w = (state_q == RUN) || (state_q == DRAIN);
    assign wrap  = run_w && (phase_q == last_c);

    // Next state; outputs are computed for the next phase so they register glitch-free.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hcnt_d  = hcnt_q;
        rate_d  = rate_q;
        lrclk_d = 1'b0;
        bclk_d  = 1'b0;
        tick_d  = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (wrap) begin
                    if (!enable) begin
                        state_d = IDLE;
                        phase_d = '0;
                        hcnt_d  = '0;
                    end else begin
                        state_d = RUN;
                        start   = 1'b1;
                    end
                end else begin
                    state_d = enable ? RUN : DRAIN;
                    phase_d = phase_q + CNT_W'(1);
                    lrclk_d = (phase_d < half_c);
                    if (hcnt_q == hlast_c) begin
                        hcnt_d = '0;
                        bclk_d = ~bclk_q;
                    end else begin
                        hcnt_d = hcnt_q + CNT_W'(1);
                        bclk_d = bclk_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                hcnt_d  = '0;
            end
        endcase
        if (start) begin
            rate_d  = rate_sel;
            phase_d = '0;
            hcnt_d  = '0;
            lrclk_d = 1'b1;
            bclk_d  = 1'b0;
            tick_d  = 1'b1;
        end
    end

    // State, phase and registered clock outputs.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            hcnt_q  <= '0;
            rate_q  <= 2'd0;
            lrclk_q <= 1'b0;
            bclk_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
            rate_q  <= rate_d;
            lrclk_q <= lrclk_d;
            bclk_q  <= bclk_d;
            tick_q  <= tick_d;
        end
    end

    // Completed-frame counter, bumped on every wrap.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            frame_q <= 16'd0;
        end else if (wrap) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    assign lrclk         = lrclk_q;
    assign bclk          = bclk_q;
    assign sample_tick   = tick_q;
    assign active_rate   = rate_q;
    assign running       = run_w;
    assign rate_pending  = run_w && (rate_sel != rate_q);
    assign frame_cnt_out = frame_q;

endmodule
